// File: rtl/alu_pipe_adder_pkg.sv
// Shared ALU definitions: default datapath width, pipeline depth limits and flag bit positions.
package alu_pipe_adder_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ZERO     = 2;
  localparam int unsigned FLAG_W        = 3;

  // Bits handled by each pipeline stage.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/alu_adder_slice.sv
// One combinational adder slice: sum, carry out, and the carry into the slice MSB.
module alu_adder_slice #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

  // Carry into the MSB recovered from the MSB sum bit.
  assign cmsb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/alu_pipe_adder.sv
// Pipelined add/subtract unit: carry rippled across per-stage slices, valid/ready handshake,
// flush, sideband tag and carry/overflow/zero flags.
module alu_pipe_adder
  import alu_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_WIDTH,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("alu_pipe_adder: WIDTH must divide evenly into 1..4 STAGES");
  end

  logic              stall;
  logic              adv;
  logic              accept;
  logic [WIDTH-1:0]  b_cond;
  logic [STAGES-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [STAGES-1:0] carry_c;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  sum_nx;
  logic              ovf_c;
  logic              ovf_q;
  logic              zero_q;
  logic              last_vld_c;

  // Handshake: a stalled output freezes the whole pipe; flush blocks new input.
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall && !flush;
  assign accept   = in_valid && in_ready;

  assign b_cond = in_b ^ {WIDTH{in_sub}};

  // Valid bits and tags travel together, one entry per stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) tag_q[k] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= accept;
      tag_q[0] <= in_tag;
      for (int k = 1; k < int'(STAGES); k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    logic [SW-1:0] a_s;
    logic [SW-1:0] b_s;
    logic [SW-1:0] sum_s;
    logic          cin_s;
    logic          cout_s;
    logic          cmsb_s;

    if (j == 0) begin : g_head
      assign a_s   = in_a[SW-1:0];
      assign b_s   = b_cond[SW-1:0];
      assign cin_s = in_sub;
    end else begin : g_skew
      // Operand skew: slice j waits j cycles for the carry from slice j-1.
      logic [SW-1:0] a_d [j];
      logic [SW-1:0] b_d [j];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < j; i++) begin
            a_d[i] <= '0;
            b_d[i] <= '0;
          end
        end else if (adv) begin
          a_d[0] <= in_a[j*SW +: SW];
          b_d[0] <= b_cond[j*SW +: SW];
          for (int i = 1; i < j; i++) begin
            a_d[i] <= a_d[i-1];
            b_d[i] <= b_d[i-1];
          end
        end
      end

      assign a_s   = a_d[j-1];
      assign b_s   = b_d[j-1];
      assign cin_s = carry_q[j-1];
    end

    alu_adder_slice #(.W(SW)) u_slice (
      .a    (a_s),
      .b    (b_s),
      .cin  (cin_s),
      .sum  (sum_s),
      .cout (cout_s),
      .cmsb (cmsb_s)
    );

    assign carry_c[j] = cout_s;

    if (j < STAGES - 1) begin : g_align
      // Deskew: finished low slices wait for the upper slices of the same operation.
      logic [SW-1:0] sum_d [STAGES-1-j];
      logic          unused_cmsb;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(STAGES - 1 - j); i++) sum_d[i] <= '0;
        end else if (adv) begin
          sum_d[0] <= sum_s;
          for (int i = 1; i < int'(STAGES - 1 - j); i++) sum_d[i] <= sum_d[i-1];
        end
      end

      assign sum_nx[j*SW +: SW] = sum_d[STAGES-2-j];
      assign unused_cmsb        = cmsb_s;
    end else begin : g_tail
      assign sum_nx[j*SW +: SW] = sum_s;
      assign ovf_c              = cmsb_s ^ cout_s;
    end
  end

  if (STAGES == 1) begin : g_vld_single
    assign last_vld_c = accept;
  end else begin : g_vld_multi
    assign last_vld_c = vld_q[STAGES-2];
  end

  // Inter-slice carries, final result and flags; zero is never shown on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= '0;
      out_sum <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (flush) begin
      zero_q  <= 1'b0;
    end else if (adv) begin
      carry_q <= carry_c;
      out_sum <= sum_nx;
      ovf_q   <= ovf_c;
      zero_q  <= last_vld_c && (sum_nx == '0);
    end
  end

  assign out_valid    = vld_q[STAGES-1];
  assign out_tag      = tag_q[STAGES-1];
  assign out_carry    = carry_q[STAGES-1];
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule
